msdap_p2s_tx: RTL and testbench



---
 rtl/msdap_pkg.sv | 11 +
 rtl/p2s_shift_reg.sv | 29 ++
 rtl/msdap_p2s_tx.sv | 129 ++++++++++++
 tb/tb_msdap_p2s_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: datapath width, serializer FSM states and bit-counter type.
package msdap_pkg;

  localparam int unsigned MSDAP_DATA_W = 40;
  localparam int unsigned MSDAP_CNT_W  = 6;

  typedef enum logic {IDLE, SHIFT} p2s_state_e;

  typedef logic [MSDAP_CNT_W-1:0] p2s_cnt_t;

endpackage

// File: rtl/p2s_shift_reg.sv
// Per-channel loadable MSB-first shift register; priority clear > load > shift.
module p2s_shift_reg
  import msdap_pkg::*;
#(
  parameter int unsigned W = MSDAP_DATA_W
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/msdap_p2s_tx.sv
// MSDAP output serializer: shifts a left/right result pair out MSB-first with a frame marker.
// Optional even-parity bit per channel after the LSB when MSDAP_P2S_PARITY_EN is defined.
module msdap_p2s_tx
  import msdap_pkg::*;
#(
  parameter int unsigned DATA_W = MSDAP_DATA_W,
  parameter int unsigned CNT_W  = MSDAP_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p2s_clear,
  input  logic              p2s_load,
  input  logic              p2s_en,
  input  logic [DATA_W-1:0] data_l,
  input  logic [DATA_W-1:0] data_r,
  output logic              out_ready,
  output logic              out_frame,
  output logic              out_l,
  output logic              out_r,
  output logic              busy,
  output logic              overrun
);

`ifdef MSDAP_P2S_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + 1;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  p2s_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame;
  logic             r_busy;
  logic             r_ovr;

  logic               w_at_last;
  logic               w_sr_clear;
  logic               w_sr_load;
  logic               w_sr_shift;
  logic [FRAME_W-1:0] w_word_l;
  logic [FRAME_W-1:0] w_word_r;

`ifdef MSDAP_P2S_PARITY_EN
  assign w_word_l = {data_l, ^data_l};
  assign w_word_r = {data_r, ^data_r};
`else
  assign w_word_l = data_l;
  assign w_word_r = data_r;
`endif

  assign w_at_last = (r_state == SHIFT) && p2s_en && (r_cnt == LAST);
  assign out_ready = (r_state == IDLE) || w_at_last;

  // The shift registers double as the output flops, so ending a word clears them to zero.
  assign w_sr_clear = !reset_n || p2s_clear || (w_at_last && !p2s_load);
  assign w_sr_load  = p2s_load && out_ready;
  assign w_sr_shift = (r_state == SHIFT) && p2s_en && (r_cnt != LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || p2s_clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (p2s_load && !out_ready) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (p2s_load) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_frame <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (p2s_en) begin
            if (r_cnt == LAST) begin
              if (p2s_load) begin
                r_cnt   <= '0;
                r_frame <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_frame <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_frame <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  p2s_shift_reg #(
    .W(FRAME_W)
  ) u_sr_l (
    .clk     (clk),
    .i_clear (w_sr_clear),
    .i_load  (w_sr_load),
    .i_shift (w_sr_shift),
    .i_data  (w_word_l),
    .o_msb   (out_l)
  );

  p2s_shift_reg #(
    .W(FRAME_W)
  ) u_sr_r (
    .clk     (clk),
    .i_clear (w_sr_clear),
    .i_load  (w_sr_load),
    .i_shift (w_sr_shift),
    .i_data  (w_word_r),
    .o_msb   (out_r)
  );

  assign out_frame = r_frame;
  assign busy      = r_busy;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_msdap_p2s_tx.sv
// Self-checking bench for msdap_p2s_tx: vector table, corner-case sequences and random traffic
// against a frame-position reference model. Honours MSDAP_P2S_PARITY_EN.
module tb_msdap_p2s_tx;

  localparam int DW = 40;
`ifdef MSDAP_P2S_PARITY_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif

  logic          clk = 1'b0;
  logic          reset_n, p2s_clear, p2s_load, p2s_en;
  logic [DW-1:0] data_l, data_r;
  logic          out_ready, out_frame, out_l, out_r, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position of the bit on the outputs within the frame, -1 when idle.
  int            m_pos = -1;
  logic [FW-1:0] m_l, m_r;
  bit            m_ovr = 1'b0;

  always #5 clk = ~clk;

  msdap_p2s_tx #(
    .DATA_W(DW),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .p2s_clear(p2s_clear),
    .p2s_load (p2s_load),
    .p2s_en   (p2s_en),
    .data_l   (data_l),
    .data_r   (data_r),
    .out_ready(out_ready),
    .out_frame(out_frame),
    .out_l    (out_l),
    .out_r    (out_r),
    .busy     (busy),
    .overrun  (overrun)
  );

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] d);
`ifdef MSDAP_P2S_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  function automatic bit m_ready(input bit en);
    return (m_pos < 0) || (en && m_pos == FW - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check out_ready before the edge, advance model, check outputs.
  task automatic step(input bit rn, input bit clr, input bit ld, input bit en,
                      input logic [DW-1:0] dl, input logic [DW-1:0] dr);
    bit rdy;
    reset_n   = rn;
    p2s_clear = clr;
    p2s_load  = ld;
    p2s_en    = en;
    data_l    = dl;
    data_r    = dr;
    #1;
    rdy = m_ready(en);
    chk("out_ready", 64'(out_ready), 64'(rdy));
    @(posedge clk);
    if (!rn || clr) begin
      m_pos = -1;
      m_ovr = 1'b0;
    end else begin
      if (ld && !rdy) m_ovr = 1'b1;
      if (ld && rdy) begin
        m_l   = frame_of(dl);
        m_r   = frame_of(dr);
        m_pos = 0;
      end else if (m_pos >= 0 && en) begin
        m_pos = (m_pos == FW - 1) ? -1 : m_pos + 1;
      end
    end
    #1;
    chk("out_l", 64'(out_l), 64'((m_pos >= 0) ? m_l[FW-1-m_pos] : 1'b0));
    chk("out_r", 64'(out_r), 64'((m_pos >= 0) ? m_r[FW-1-m_pos] : 1'b0));
    chk("out_frame", 64'(out_frame), 64'(m_pos == 0));
    chk("busy", 64'(busy), 64'(m_pos >= 0));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  typedef struct {
    logic rn, clr, ld, en;
    logic [DW-1:0] dl, dr;
    logic el, er, ef, eb, eo;
  } vec_t;

  initial begin
    vec_t          tbl[10];
    logic [FW-1:0] got_l, got_r;
    logic [63:0]   rnd_l, rnd_r;
    int            frames, cyc;
    logic          held_l, held_r;

    reset_n = 1'b0; p2s_clear = 1'b0; p2s_load = 1'b0; p2s_en = 1'b0;
    data_l = '0; data_r = '0;
    repeat (2) @(posedge clk);
    #1;

    //            rn    clr   ld    en    data_l              data_r           l     r     f     b     ov
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 40'h0,              40'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 40'h80_0000_0001,   40'h00_0000_0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 40'h0,              40'h0,           1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 40'h0,              40'h0,           1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 40'hFF_FFFF_FFFF,   40'hFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 40'hFF_FFFF_FFFF,   40'hFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 40'hC0_0000_0000,   40'h40_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 40'h0,              40'h0,           1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 40'h0,              40'h0,           1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFF,   40'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    m_pos = -1;
    m_ovr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rn, tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].dl, tbl[i].dr);
      chk($sformatf("vec%0d_l", i), 64'(out_l), 64'(tbl[i].el));
      chk($sformatf("vec%0d_r", i), 64'(out_r), 64'(tbl[i].er));
      chk($sformatf("vec%0d_frame", i), 64'(out_frame), 64'(tbl[i].ef));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].eb));
      chk($sformatf("vec%0d_ovr", i), 64'(overrun), 64'(tbl[i].eo));
    end

    // Single word, continuous enable.
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h80_0000_0001, 40'h00_0000_0002);
    got_l[FW-1] = out_l;
    got_r[FW-1] = out_r;
    frames = int'(out_frame);
    for (int i = 1; i < FW; i++) begin
      idle_step();
      got_l[FW-1-i] = out_l;
      got_r[FW-1-i] = out_r;
      frames += int'(out_frame);
    end
    chk("single_l_bits", 64'(got_l), 64'(frame_of(40'h80_0000_0001)));
    chk("single_r_bits", 64'(got_r), 64'(frame_of(40'h00_0000_0002)));
    chk("single_frames", 64'(frames), 64'd1);
    idle_step();
    chk("single_end_busy", 64'(busy), 64'd0);
    chk("single_end_ready", 64'(out_ready), 64'd1);

    // Back-to-back: second load exactly on the last bit.
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'hAA_AAAA_AAAA, 40'h55_5555_5555);
    frames = 0;
    for (int i = 1; i < FW; i++) begin
      idle_step();
      frames += int'(out_frame);
    end
    chk("b2b_no_early_frame", 64'(frames), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h55_5555_5555, 40'hAA_AAAA_AAAA);
    chk("b2b_frame_period", 64'(out_frame), 64'd1);
    chk("b2b_msb", 64'(out_l), 64'd0);
    chk("b2b_no_overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < FW; i++) idle_step();
    chk("b2b_done", 64'(busy), 64'd0);

    // Stall for 5 cycles at bit 10.
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h12_3456_789A, 40'hFE_DCBA_9876);
    for (int i = 0; i < 10; i++) idle_step();
    held_l = out_l;
    held_r = out_r;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("stall_hold_l", 64'(out_l), 64'(held_l));
      chk("stall_hold_r", 64'(out_r), 64'(held_r));
    end
    cyc = 15;
    while (busy && cyc < 200) begin
      idle_step();
      cyc++;
    end
    chk("stall_total_cycles", 64'(cyc), 64'(FW + 5));

    // Overrun at bit 20, sticky until clear.
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0);
    for (int i = 0; i < 20; i++) idle_step();
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
    chk("ovr_set", 64'(overrun), 64'd1);
    for (int i = 21; i < FW + 1; i++) idle_step();
    chk("ovr_sticky_idle", 64'(overrun), 64'd1);
    chk("ovr_word_done", 64'(busy), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Abort at bit 15 with clear, then with reset; the concurrent load is dropped.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
      for (int i = 0; i < 15; i++) idle_step();
      step((k == 1) ? 1'b0 : 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1,
           40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_out_l", 64'(out_l), 64'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      chk("abort_not_captured", 64'(busy), 64'd0);
    end

`ifdef MSDAP_P2S_PARITY_EN
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h00_0000_0007, 40'h00_0000_0003);
    for (int i = 1; i < FW; i++) idle_step();
    chk("parity_bit_l", 64'(out_l), 64'd1);
    chk("parity_bit_r", 64'(out_r), 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 40'h0, 40'h0);
    chk("parity_frame_period", 64'(out_frame), 64'd1);
    for (int i = 0; i < FW; i++) idle_step();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rnd_l = {$urandom(), $urandom()};
      rnd_r = {$urandom(), $urandom()};
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           rnd_l[DW-1:0], rnd_r[DW-1:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
